// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing for the DSP-clock PLL supervisor/phase sequencer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_IDLE      = 3'd2,
    ST_SETUP     = 3'd3,
    ST_STEP_HI   = 3'd4,
    ST_STEP_LO   = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_TIMEOUT = 4096;
  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_PULSE_CYCLES = 4;
  localparam int DEF_GAP_CYCLES   = 4;
  localparam int DEF_CNT_W        = 8;

  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser; output lags input by two clock edges.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL supervisor (reset/lock watchdog) and PHASESEL/PHASEDIR/PHASESTEP sequencer.
// All outputs registered from next state; REQ is only sampled in IDLE, never queued.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOCK,
  input  logic             REQ,
  input  logic [1:0]       SEL,
  input  logic             DIR,
  input  logic [CNT_W-1:0] NSTEPS,
  output logic             ACK,
  output logic             ERR,
  output logic             BUSY,
  output logic             PLL_LOCKED,
  output logic [7:0]       LOSS_CNT,
  output logic             PLL_RST,
  output logic [1:0]       PHASESEL,
  output logic             PHASEDIR,
  output logic             PHASESTEP
);

  localparam int TMR_MAX = max_int(max_int(LOCK_TIMEOUT, RST_CYCLES),
                                   max_int(SETUP_CYCLES, max_int(PULSE_CYCLES, GAP_CYCLES)));
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Timer loads hold N-1 so each state lasts exactly N cycles.
  localparam logic [TMR_W-1:0] TMR_RST   = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LOCK  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_SETUP = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_PULSE = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_GAP   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             lock_s;
  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [1:0]       sel_q, sel_d;
  logic             dir_q, dir_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [7:0]       loss_q, loss_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;
  logic             pll_rst_q, pll_rst_d;
  logic             pstep_q, pstep_d;
  logic             loss_inc;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (LOCK),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    step_d   = step_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    loss_inc = 1'b0;

    unique case (state_q)
      ST_RESET_PLL: begin
        if (tmr_q == '0) begin
          state_d = ST_WAIT_LOCK;
          tmr_d   = TMR_LOCK;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          loss_inc = 1'b1;
          state_d  = ST_RESET_PLL;
          tmr_d    = TMR_RST;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_IDLE: begin
        if (!lock_s) begin
          loss_inc = 1'b1;
          state_d  = ST_RESET_PLL;
          tmr_d    = TMR_RST;
        end else if (REQ) begin
          step_d = NSTEPS;
          if (NSTEPS == '0) begin
            state_d = ST_DONE;
          end else begin
            sel_d   = SEL;
            dir_d   = DIR;
            state_d = ST_SETUP;
            tmr_d   = TMR_SETUP;
          end
        end
      end
      ST_SETUP, ST_STEP_HI, ST_STEP_LO: begin
        if (!lock_s) begin
          // Abort: the PLL is about to be reset, so the pulse train is meaningless.
          ack_d    = 1'b1;
          err_d    = 1'b1;
          loss_inc = 1'b1;
          state_d  = ST_RESET_PLL;
          tmr_d    = TMR_RST;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_ONE;
        end else if (state_q == ST_SETUP) begin
          state_d = ST_STEP_HI;
          tmr_d   = TMR_PULSE;
        end else if (state_q == ST_STEP_HI) begin
          state_d = ST_STEP_LO;
          tmr_d   = TMR_GAP;
        end else if (step_q == CNT_ONE) begin
          step_d  = '0;
          state_d = ST_DONE;
        end else begin
          step_d  = step_q - CNT_ONE;
          state_d = ST_STEP_HI;
          tmr_d   = TMR_PULSE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_RESET_PLL;
        tmr_d   = TMR_RST;
      end
    endcase

    if (state_d == ST_DONE) begin
      ack_d = 1'b1;
    end
  end

  assign loss_d    = (loss_inc && (loss_q != 8'hFF)) ? loss_q + 8'd1 : loss_q;
  assign busy_d    = (state_d != ST_IDLE);
  assign locked_d  = (state_d != ST_RESET_PLL) && (state_d != ST_WAIT_LOCK);
  assign pll_rst_d = (state_d == ST_RESET_PLL);
  assign pstep_d   = (state_d == ST_STEP_HI);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_RESET_PLL;
      tmr_q     <= TMR_RST;
      step_q    <= '0;
      sel_q     <= SEL_CLKOP;
      dir_q     <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      loss_q    <= 8'd0;
      busy_q    <= 1'b1;
      locked_q  <= 1'b0;
      pll_rst_q <= 1'b1;
      pstep_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      step_q    <= step_d;
      sel_q     <= sel_d;
      dir_q     <= dir_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      loss_q    <= loss_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
      pll_rst_q <= pll_rst_d;
      pstep_q   <= pstep_d;
    end
  end

  assign ACK        = ack_q;
  assign ERR        = err_q;
  assign BUSY       = busy_q;
  assign PLL_LOCKED = locked_q;
  assign LOSS_CNT   = loss_q;
  assign PLL_RST    = pll_rst_q;
  assign PHASESEL   = sel_q;
  assign PHASEDIR   = dir_q;
  assign PHASESTEP  = pstep_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl; LOCK_TIMEOUT shortened to 64 so the saturation run stays short.
module tb_pll_phase_ctrl;

  logic       clk;
  logic       rst;
  logic       lock;
  logic       req;
  logic [1:0] sel;
  logic       dir;
  logic [7:0] nsteps;
  logic       ack;
  logic       err;
  logic       busy;
  logic       pll_locked;
  logic [7:0] loss_cnt;
  logic       pll_rst;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;

  int total = 0;
  int bad   = 0;

  pll_phase_ctrl #(
    .RST_CYCLES   (16),
    .LOCK_TIMEOUT (64),
    .SETUP_CYCLES (2),
    .PULSE_CYCLES (4),
    .GAP_CYCLES   (4),
    .CNT_W        (8)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .LOCK       (lock),
    .REQ        (req),
    .SEL        (sel),
    .DIR        (dir),
    .NSTEPS     (nsteps),
    .ACK        (ack),
    .ERR        (err),
    .BUSY       (busy),
    .PLL_LOCKED (pll_locked),
    .LOSS_CNT   (loss_cnt),
    .PLL_RST    (pll_rst),
    .PHASESEL   (phasesel),
    .PHASEDIR   (phasedir),
    .PHASESTEP  (phasestep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and traces cycles 1..ncyc; cycle c is sampled just after the c-th edge.
  task automatic run_req(input logic [1:0] s, input logic d, input logic [7:0] n, input int ncyc,
                         output int first_rise, output int rises, output int highs,
                         output int ack_cyc, output int acks, output int errs, output int pat_bad,
                         output logic [1:0] sel1, output logic dir1);
    logic prev;
    logic e;
    int   nn;
    nn = n;
    first_rise = -1; rises = 0; highs = 0; ack_cyc = -1; acks = 0; errs = 0; pat_bad = 0;
    sel1 = 2'd0; dir1 = 1'b0; prev = 1'b0;
    sel = s; dir = d; nsteps = n; req = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (c == 1) begin
        sel1 = phasesel;
        dir1 = phasedir;
      end
      if (phasestep && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = c;
      end
      if (phasestep) highs++;
      e = (nn != 0) && (c >= 3) && (c < 3 + 8 * nn) && (((c - 3) % 8) < 4);
      if (phasestep !== e) pat_bad++;
      if (ack) begin
        acks++;
        ack_cyc = c;
        if (err) errs++;
        req = 1'b0;
      end
      prev = phasestep;
    end
    req = 1'b0;
  endtask

  int fr, rs, hi, ac, acn, ern, pb, n, fall, rsth, last, minp, maxp, per;
  logic [1:0] s1;
  logic d1, prev;

  initial begin
    rst = 1'b1; lock = 1'b1; req = 1'b0; sel = 2'd0; dir = 1'b0; nsteps = 8'd0;
    #3;
    check("rst_pll_rst",   pll_rst,    1);
    check("rst_busy",      busy,       1);
    check("rst_phasesel",  phasesel,   0);
    check("rst_phasedir",  phasedir,   0);
    check("rst_phasestep", phasestep,  0);
    check("rst_ack",       ack,        0);
    check("rst_err",       err,        0);
    check("rst_locked",    pll_locked, 0);
    check("rst_loss",      loss_cnt,   0);

    // Power-up with LOCK tied high
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (pll_rst && n < 100) begin
      n++;
      tick();
    end
    check("pwrup_rst_len", n, 16);
    check("pwrup_wait_unlocked", pll_locked, 0);
    tick();
    check("pwrup_locked", pll_locked, 1);
    check("pwrup_busy", busy, 0);
    check("pwrup_loss", loss_cnt, 0);

    // SEL=1 DIR=1 N=3
    run_req(2'd1, 1'b1, 8'd3, 40, fr, rs, hi, ac, acn, ern, pb, s1, d1);
    check("n3_sel_c1", s1, 1);
    check("n3_dir_c1", d1, 1);
    check("n3_first_rise", fr, 3);
    check("n3_rises", rs, 3);
    check("n3_high_cycles", hi, 12);
    check("n3_pattern_bad", pb, 0);
    check("n3_ack_cycle", ac, 27);
    check("n3_ack_count", acn, 1);
    check("n3_err", ern, 0);
    check("n3_idle_busy", busy, 0);
    check("n3_sel_hold", phasesel, 1);

    // N=0
    run_req(2'd2, 1'b0, 8'd0, 8, fr, rs, hi, ac, acn, ern, pb, s1, d1);
    check("n0_ack_cycle", ac, 1);
    check("n0_ack_count", acn, 1);
    check("n0_rises", rs, 0);
    check("n0_pattern_bad", pb, 0);
    check("n0_err", ern, 0);

    // SEL=3 DIR=0 N=1
    run_req(2'd3, 1'b0, 8'd1, 16, fr, rs, hi, ac, acn, ern, pb, s1, d1);
    check("n1_sel_c1", s1, 3);
    check("n1_dir_c1", d1, 0);
    check("n1_ack_cycle", ac, 11);
    check("n1_rises", rs, 1);
    check("n1_pattern_bad", pb, 0);

    // LOCK dropped during the second pulse of an N=5 request
    sel = 2'd0; dir = 1'b0; nsteps = 8'd5; req = 1'b1;
    prev = 1'b0; fall = -1; acn = 0; ern = 0; ac = -1; rsth = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 11) begin
        check("abort_pulse2_high", phasestep, 1);
        lock = 1'b0;
      end
      if (c == 20) lock = 1'b1;
      if (c == 13) check("abort_loss_before", loss_cnt, 0);
      if (c == 14) begin
        check("abort_loss_after", loss_cnt, 1);
        check("abort_pll_rst", pll_rst, 1);
      end
      if (c > 11 && prev && !phasestep && fall < 0) fall = c;
      if (ack) begin
        acn++;
        ac = c;
        if (err) ern++;
        req = 1'b0;
      end
      if (pll_rst) rsth++;
      if (c == 30) check("relock_pending", pll_locked, 0);
      if (c == 31) check("relock_done", pll_locked, 1);
      prev = phasestep;
    end
    req = 1'b0;
    check("abort_fall_cycle", fall, 14);
    check("abort_ack_cycle", ac, 14);
    check("abort_ack_count", acn, 1);
    check("abort_err_count", ern, 1);
    check("abort_rst_len", rsth, 16);
    check("abort_final_loss", loss_cnt, 1);

    // RST asserted mid-STEP_HI
    sel = 2'd2; dir = 1'b1; nsteps = 8'd2; req = 1'b1;
    for (int c = 1; c <= 4; c++) tick();
    check("midrst_step_before", phasestep, 1);
    rst = 1'b1;
    #1;
    check("midrst_phasestep", phasestep, 0);
    check("midrst_pll_rst", pll_rst, 1);
    check("midrst_ack", ack, 0);
    check("midrst_busy", busy, 1);
    check("midrst_locked", pll_locked, 0);
    check("midrst_phasesel", phasesel, 0);
    check("midrst_loss", loss_cnt, 0);
    acn = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (ack) acn++;
    end
    check("midrst_no_ack", acn, 0);
    req = 1'b0;
    lock = 1'b0;

    // LOCK never asserts: periodic retries until LOSS_CNT saturates
    rst = 1'b0;
    prev = pll_rst; rs = 0; last = 0; minp = 1 << 30; maxp = 0;
    for (int c = 1; c <= 300 * 80 + 200 && rs < 300; c++) begin
      tick();
      if (pll_rst && !prev) begin
        rs++;
        per = c - last;
        last = c;
        if (per < minp) minp = per;
        if (per > maxp) maxp = per;
        if (rs == 1) begin
          check("to_first_rise", c, 80);
          check("to_loss1", loss_cnt, 1);
        end
        if (rs == 2) check("to_loss2", loss_cnt, 2);
        if (rs == 254) check("to_loss254", loss_cnt, 254);
      end
      prev = pll_rst;
    end
    check("to_retries", rs, 300);
    check("to_min_period", minp, 80);
    check("to_max_period", maxp, 80);
    check("to_loss_sat", loss_cnt, 255);
    check("to_unlocked", pll_locked, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Supervisor and dynamic-phase sequencer for the DSP-clock PLL (ECP5 EHXPLLL, 20 MHz in, 100/200 MHz out). Runs on the free-running reference clock. It holds the PLL in reset after power-up, watches LOCK and re-resets on loss or timeout. It also turns a simple request/acknowledge command ("move output SEL by N steps in direction DIR") into correctly timed PHASESEL/PHASEDIR/PHASESTEP sequences.

## Interface
Parameters:
- RST_CYCLES, 16: cycles PLL_RST is held high per reset attempt (≥1)
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before retrying reset
- SETUP_CYCLES, 2: PHASESEL/PHASEDIR stable time before first PHASESTEP pulse (≥1)
- PULSE_CYCLES, 4: PHASESTEP high time per step (≥1)
- GAP_CYCLES, 4: PHASESTEP low time after each pulse (≥1)
- CNT_W, 8: width of step-count field

Ports:
- CLK  in  1  reference clock (20 MHz)
- RST  in  1  asynchronous, active-high reset
- LOCK  in  1  PLL lock, asynchronous to CLK
- REQ  in  1  phase-step request, level
- SEL  in  2  target output (0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3)
- DIR  in  1  0 = lag, 1 = lead
- NSTEPS  in  CNT_W  number of phase steps
- ACK  out  1  one-cycle pulse when a request completes or aborts
- ERR  out  1  qualifies ACK: request aborted by lock loss
- BUSY  out  1  high in every state except IDLE
- PLL_LOCKED  out  1  high only in IDLE/stepping states
- LOSS_CNT  out  8  saturating count of lock losses and lock timeouts
- PLL_RST  out  1  to EHXPLLL RST
- PHASESEL  out  2  to EHXPLLL PHASESEL[1:0]
- PHASEDIR  out  1  to EHXPLLL PHASEDIR
- PHASESTEP  out  1  to EHXPLLL PHASESTEP

## Operation
- LOCK is double-flop synchronised (lock_s). All lock decisions use lock_s.
- States: RESET_PLL, WAIT_LOCK, IDLE, SETUP, STEP_HI, STEP_LO, DONE.
- RESET_PLL: PLL_RST=1 for RST_CYCLES, then WAIT_LOCK.
- WAIT_LOCK: PLL_RST=0.
  - lock_s=1 → IDLE.
  - Counter reaches LOCK_TIMEOUT → LOSS_CNT+1, then RESET_PLL.
- IDLE:
  - lock_s=0 → LOSS_CNT+1, then RESET_PLL.
  - Otherwise REQ=1 latches SEL/DIR/NSTEPS.
    - NSTEPS=0 → DONE.
    - Else → SETUP, driving PHASESEL/PHASEDIR from the latched values.
- SETUP: SETUP_CYCLES, then STEP_HI.
- STEP_HI: PHASESTEP=1 for PULSE_CYCLES, then STEP_LO.
- STEP_LO: PHASESTEP=0 for GAP_CYCLES, then decrement remaining.
  - Remaining = 0 → DONE.
  - Else → STEP_HI.
- DONE: ACK=1 for one cycle, then IDLE.
- Lock loss (lock_s=0) in SETUP/STEP_HI/STEP_LO:
  - PHASESTEP goes 0 immediately (registered, next cycle).
  - ACK=1 and ERR=1 for one cycle.
  - LOSS_CNT+1, then RESET_PLL.
- PHASESEL/PHASEDIR hold their last driven value between requests.
- REQ while BUSY is ignored, not queued. The requester must hold REQ until ACK and drop it the cycle after. REQ still high in IDLE after DONE starts a new request.
- LOSS_CNT saturates at 255. Cleared only by RST.

## Timing
- All outputs are registered.
- Reset values:
  - PLL_RST=1, BUSY=1
  - PHASESEL=0, PHASEDIR=0, PHASESTEP=0
  - ACK=0, ERR=0, PLL_LOCKED=0, LOSS_CNT=0
  - State = RESET_PLL
- After RST deasserts, PLL_RST stays high exactly RST_CYCLES cycles.
- LOCK-to-lock_s latency is 2 cycles. PLL_LOCKED rises 1 cycle after lock_s in WAIT_LOCK.
- Request latency, with REQ sampled in IDLE at cycle 0:
  - First PHASESTEP rise at cycle 1+SETUP_CYCLES.
  - ACK at cycle 1+SETUP_CYCLES+N·(PULSE_CYCLES+GAP_CYCLES).
  - N=0: ACK at cycle 1, no PHASESTEP activity.
- RST asserted mid-sequence: all outputs return to reset values asynchronously. No ACK is issued.

## Structure
- Package pll_ctrl_pkg holds:
  - state enum
  - default timing constants
  - SEL encoding constants (SEL_CLKOP..SEL_CLKOS3)
- Sub-module sync_2ff: generic 1-bit two-flop synchroniser, used for LOCK.
- Timers: one shared down-counter sized for max(LOCK_TIMEOUT, RST_CYCLES, SETUP_CYCLES, PULSE_CYCLES, GAP_CYCLES), plus a CNT_W step counter.

## Test plan
- Power-up, LOCK tied high: PLL_RST high 16 cycles after RST release; PLL_LOCKED=1 by cycle 16+4; LOSS_CNT=0.
- LOCK never asserts: PLL_RST re-pulses every 16+4096 cycles; LOSS_CNT increments each retry; after 300 retries it reads 255.
- REQ with SEL=1, DIR=1, NSTEPS=3:
  - PHASESEL=1 and PHASEDIR=1 from cycle 1.
  - Exactly 3 PHASESTEP pulses, each 4 high / 4 low, first rise at cycle 3.
  - ACK at cycle 27 with ERR=0.
- REQ with NSTEPS=0: ACK at cycle 1; PHASESTEP never toggles.
- LOCK dropped during 2nd pulse of an NSTEPS=5 request: PHASESTEP low within 3 cycles; ACK=ERR=1 once; LOSS_CNT=1; PLL_RST pulses; relocks to IDLE.
- RST asserted mid-STEP_HI: PHASESTEP=0 and PLL_RST=1 immediately; no ACK pulse observed.
